// File: rtl/out_port_pkg.sv
// Shared definitions for the out_port BCD display:
// FSM state encoding and active-low gfedcba segment codes.
package out_port_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // 10^n, used to check the digit count covers the input range
   function automatic longint pow10(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// One BCD digit to active-low gfedcba segments.
// Nibbles above 9 decode to a blank digit.
import out_port_pkg::*;

module seven_seg_decoder (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Table lookup of the segment pattern
   always_comb begin
      seg = SEG_BLANK;
      unique case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/out_port_bcd_display.sv
// Shows a CPU out_port word in decimal on active-low 7-seg digits,
// converting with iterative shift-and-add-3. Option: OUT_PORT_LEADING_ZERO_BLANK_EN.
import out_port_pkg::*;

module out_port_bcd_display #(
   parameter int DATA_W = 16,
   parameter int DIGITS = 5
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [31:0]         port_data,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [7*DIGITS-1:0] seg_out,
   output logic                busy,
   output logic                valid
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int SEG_W = 7 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   generate
      if (pow10(DIGITS) - 1 < (longint'(1) << DATA_W) - 1) begin : g_range_chk
         $error("DIGITS too small for DATA_W");
      end
   endgenerate

   state_t             state;
   logic [DATA_W-1:0]  port_val;
   logic [DATA_W-1:0]  shift_reg;
   logic [DATA_W-1:0]  last_value;
   logic [BCD_W-1:0]   bcd_work;
   logic [BCD_W-1:0]   bcd_adj;
   logic [CNT_W-1:0]   count;
   logic [SEG_W-1:0]   dec_seg;
   logic [SEG_W-1:0]   seg_next;

   assign port_val = port_data[DATA_W-1:0];

   // Add 3 to every nibble that would overflow past 9 when doubled
   always_comb begin
      bcd_adj = bcd_work;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_work[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_dec
         seven_seg_decoder u_dec (
            .bcd (bcd_work[4*g +: 4]),
            .seg (dec_seg[7*g +: 7])
         );
      end
   endgenerate

   // Segment image to latch in DONE, optionally blanking leading zeros
   always_comb begin
      seg_next = dec_seg;
`ifdef OUT_PORT_LEADING_ZERO_BLANK_EN
      begin : blank_lead
         logic lead;
         lead = 1'b1;
         for (int i = DIGITS - 1; i >= 1; i--) begin
            lead = lead & (bcd_work[4*i +: 4] == 4'd0);
            if (lead) begin
               seg_next[7*i +: 7] = SEG_BLANK;
            end
         end
      end
`endif
   end

   // Conversion FSM with registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         shift_reg  <= '0;
         last_value <= '0;
         bcd_work   <= '0;
         count      <= '0;
         bcd_out    <= '0;
         seg_out    <= '1;
         busy       <= 1'b0;
         valid      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!valid || port_val != last_value) begin
                  shift_reg  <= port_val;
                  last_value <= port_val;
                  bcd_work   <= '0;
                  count      <= '0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               {bcd_work, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
               count <= count + 1'b1;
               if (count == CNT_W'(DATA_W - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               bcd_out <= bcd_work;
               seg_out <= seg_next;
               valid   <= 1'b1;
               busy    <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_out_port_bcd_display.sv
// Directed bench for out_port_bcd_display: table of port values plus
// hand-written sequences for back-to-back changes and mid-conversion reset.
module tb_out_port_bcd_display;

   logic        clk;
   logic        reset;
   logic [31:0] port_data;
   logic [19:0] bcd_out;
   logic [34:0] seg_out;
   logic        busy;
   logic        valid;

   int checks = 0;
   int failures = 0;

   out_port_bcd_display #(.DATA_W(16), .DIGITS(5)) dut (
      .clock     (clk),
      .reset     (reset),
      .port_data (port_data),
      .bcd_out   (bcd_out),
      .seg_out   (seg_out),
      .busy      (busy),
      .valid     (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic [19:0] bcd;
      logic [34:0] seg;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Wait for busy to drop; n = edges counted after the start edge
   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 100);
      if (busy) begin
         failures++;
         checks++;
         $display("FAIL timeout: busy still %0b after %0d cycles", busy, n);
      end
   endtask

   int n;
   int busy_seen;

   initial begin
      vecs[0].data = 32'd0;
      vecs[0].bcd  = 20'h00000;
      vecs[1].data = 32'd1234;
      vecs[1].bcd  = 20'h01234;
      vecs[2].data = 32'hFFFF_FFFF;
      vecs[2].bcd  = 20'h65535;
      vecs[3].data = 32'd10000;
      vecs[3].bcd  = 20'h10000;
      vecs[4].data = 32'd7;
      vecs[4].bcd  = 20'h00007;
      vecs[5].data = 32'd90;
      vecs[5].bcd  = 20'h00090;
`ifdef OUT_PORT_LEADING_ZERO_BLANK_EN
      vecs[0].seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
      vecs[1].seg = {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19};
      vecs[4].seg = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
      vecs[5].seg = {7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h40};
`else
      vecs[0].seg = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
      vecs[1].seg = {7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
      vecs[4].seg = {7'h40, 7'h40, 7'h40, 7'h40, 7'h78};
      vecs[5].seg = {7'h40, 7'h40, 7'h40, 7'h10, 7'h40};
`endif
      vecs[2].seg = {7'h02, 7'h12, 7'h12, 7'h30, 7'h12};
      vecs[3].seg = {7'h79, 7'h40, 7'h40, 7'h40, 7'h40};

      // Reset state
      reset = 1'b1;
      port_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bcd", 64'(bcd_out), 64'h0);
      check("rst_seg", 64'(seg_out), 64'h7_FFFF_FFFF);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_valid", 64'(valid), 64'h0);
      reset = 1'b0;

      // Table: each value differs from the previous, so each converts
      for (int i = 0; i < 6; i++) begin
         port_data = vecs[i].data;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_busy_start", i), 64'(busy), 64'h1);
         wait_done(n);
         check($sformatf("v%0d_latency", i), 64'(n), 64'd17);
         check($sformatf("v%0d_valid", i), 64'(valid), 64'h1);
         check($sformatf("v%0d_bcd", i), 64'(bcd_out), 64'(vecs[i].bcd));
         check($sformatf("v%0d_seg", i), 64'(seg_out), 64'(vecs[i].seg));
      end

      // Unchanged input: no reconversion, outputs hold
      busy_seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (busy) busy_seen++;
      end
      check("hold_busy", 64'(busy_seen), 64'd0);
      check("hold_bcd", 64'(bcd_out), 64'(vecs[5].bcd));
      check("hold_seg", 64'(seg_out), 64'(vecs[5].seg));

      // 42 then 77 during the conversion
      port_data = 32'd42;
      @(posedge clk);
      #1;
      check("c42_busy_start", 64'(busy), 64'h1);
      repeat (4) @(posedge clk);
      port_data = 32'd77;
      wait_done(n);
      check("c42_latency", 64'(n + 4), 64'd17);
      check("c42_bcd", 64'(bcd_out), 64'h00042);
`ifdef OUT_PORT_LEADING_ZERO_BLANK_EN
      check("c42_seg", 64'(seg_out),
            64'({7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}));
`else
      check("c42_seg", 64'(seg_out),
            64'({7'h40, 7'h40, 7'h40, 7'h19, 7'h24}));
`endif
      @(posedge clk);
      #1;
      check("c77_busy_start", 64'(busy), 64'h1);
      wait_done(n);
      check("c77_latency", 64'(n), 64'd17);
      check("c77_bcd", 64'(bcd_out), 64'h00077);
      busy_seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (busy) busy_seen++;
      end
      check("c77_no_rerun", 64'(busy_seen), 64'd0);

      // Reset in the middle of converting 999
      port_data = 32'd999;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #1;
      check("r999_busy_mid", 64'(busy), 64'h1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("r999_busy", 64'(busy), 64'h0);
      check("r999_valid", 64'(valid), 64'h0);
      check("r999_seg", 64'(seg_out), 64'h7_FFFF_FFFF);
      check("r999_bcd", 64'(bcd_out), 64'h0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("r999_restart", 64'(busy), 64'h1);
      wait_done(n);
      check("r999_latency", 64'(n), 64'd17);
      check("r999_bcd_final", 64'(bcd_out), 64'h00999);
`ifdef OUT_PORT_LEADING_ZERO_BLANK_EN
      check("r999_seg_final", 64'(seg_out),
            64'({7'h7F, 7'h7F, 7'h10, 7'h10, 7'h10}));
`else
      check("r999_seg_final", 64'(seg_out),
            64'({7'h40, 7'h40, 7'h10, 7'h10, 7'h10}));
`endif
      check("r999_valid_final", 64'(valid), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
